// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch path.
// A fetch entry pairs a program counter with the word read from that address.
package fetch_pkg;

    localparam int          WORD_W           = 32;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
    } fetch_entry_t;

    // Word-aligns a byte address by clearing the two low bits.
    function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with a flush that empties it at the edge.
// Pointers wrap modulo DEPTH, which must be a power of two of at least 2.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    output fetch_entry_t     head_data,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty   = (count == '0);
        full    = (count == CNT_W'(DEPTH));
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
    end

    // Storage carries no reset; entries are only observed once count covers them.
    always_ff @(posedge clock) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_data = mem[rd_ptr];

    overflow_guard: assert property (@(posedge clock) disable iff (!reset_n)
        (push && !flush) |-> (!full || pop));

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch front end: owns the PC, tracks the single outstanding memory read,
// and buffers returned words so decode back-pressure never drops data.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic [31:0] read_address,
    input  logic [31:0] instruction,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instruction,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4
);

    // Handshake: an entry transfers on every rising edge where out_valid and
    // out_ready are both high; out_valid never drops without a pop or redirect.

    localparam int          CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam logic [31:0] BOOT_PC    = word_align(RESET_PC);

    logic [31:0]      pc_q;
    logic             inflight_q;
    logic [31:0]      inflight_pc_q;

    logic             pop;
    logic             issue;
    logic             fifo_push;
    logic [CNT_W:0]   occupancy;
    logic [31:0]      redirect_pc;
    fetch_entry_t     push_entry;
    fetch_entry_t     head_entry;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic             fifo_full;

    // Occupancy counts the word still in flight so a stall never overfills the buffer.
    always_comb begin
        pop         = out_valid && out_ready;
        occupancy   = {1'b0, fifo_count}
                    + {{CNT_W{1'b0}}, inflight_q}
                    - {{CNT_W{1'b0}}, pop};
        issue       = !redirect_valid && (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
        fifo_push   = inflight_q && !redirect_valid;
        redirect_pc = word_align(redirect_target);
        push_entry  = '{pc: inflight_pc_q, instr: instruction};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q          <= BOOT_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else if (redirect_valid) begin
            pc_q       <= redirect_pc;
            inflight_q <= 1'b0;
        end else if (issue) begin
            pc_q          <= pc_q + PC_STEP;
            inflight_q    <= 1'b1;
            inflight_pc_q <= pc_q;
        end else begin
            inflight_q <= 1'b0;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (redirect_valid),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head_entry),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    always_comb begin
        read_address    = pc_q;
        out_valid       = !fifo_empty;
        out_instruction = out_valid ? head_entry.instr : '0;
        out_pc          = out_valid ? head_entry.pc    : '0;
        out_pc_plus4    = out_valid ? (head_entry.pc + PC_STEP) : '0;
    end

    push_fits: assert property (@(posedge clock) disable iff (!reset_n)
        fifo_push |-> (!fifo_full || pop));

    address_aligned: assert property (@(posedge clock) disable iff (!reset_n)
        read_address[1:0] == 2'b00);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios feed an expected queue,
// and a monitor pops and compares every entry decode accepts.
module tb_instruction_fetch_unit;
    import fetch_pkg::*;

    logic        clock;
    logic        reset_n;
    logic [31:0] read_address;
    logic [31:0] instruction;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;

    logic [63:0] exp_q[$];
    int          n_checks;
    int          n_fail;

    instruction_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .read_address    (read_address),
        .instruction     (instruction),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instruction (out_instruction),
        .out_pc          (out_pc),
        .out_pc_plus4    (out_pc_plus4)
    );

    // ---------------- clock / reset / memory ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory model: word[i] = 32'h1000_0000 + i, returned one cycle after the address.
    always @(posedge clock) begin
        instruction <= 32'h1000_0000 + {2'b00, read_address[31:2]};
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required finish before 100000");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking helpers ----------------
    function automatic void check32(input string name, input logic [31:0] act,
                                    input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endfunction

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] instr);
        exp_q.push_back({pc, instr});
    endtask

    task automatic drain_check(input string name);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d entries left, required 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clock) begin
        logic [63:0] e;
        if (reset_n === 1'b1) begin
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got pc %h instr %h, required no output",
                             out_pc, out_instruction);
                end else begin
                    e = exp_q.pop_front();
                    check32("sb_pc", out_pc, e[63:32]);
                    check32("sb_instr", out_instruction, e[31:0]);
                    check32("sb_pc_plus4", out_pc_plus4, e[63:32] + 32'd4);
                end
            end else if (out_valid === 1'b0) begin
                check32("idle_payload", out_pc | out_instruction | out_pc_plus4, 32'h0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    // Leaves the bench 1 time unit into cycle 0.
    task automatic apply_reset();
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    // Sequential fetch from cycle 0 with out_ready high; ends at cycle 10.
    task automatic seq_body(input string name);
        for (int i = 0; i < 8; i++) begin
            push_exp(32'(i * 4), 32'h1000_0000 + 32'(i));
        end
        sample();
        check32({name, "_c0_addr"}, read_address, 32'h0);
        check32({name, "_c0_valid"}, {31'b0, out_valid}, 32'h0);
        next_cycle();
        sample();
        check32({name, "_c1_valid"}, {31'b0, out_valid}, 32'h0);
        check32({name, "_c1_addr"}, read_address, 32'h4);
        next_cycle();
        sample();
        check32({name, "_c2_valid"}, {31'b0, out_valid}, 32'h1);
        check32({name, "_c2_pc"}, out_pc, 32'h0);
        repeat (8) next_cycle();
        drain_check(name);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        n_checks        = 0;
        n_fail          = 0;
        reset_n         = 1'b0;
        out_ready       = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;

        // Reset and sequential fetch.
        out_ready = 1'b1;
        apply_reset();
        seq_body("seq");

        // Back-pressure: decode stalls from cycle 0 to cycle 6.
        out_ready = 1'b0;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            push_exp(32'(i * 4), 32'h1000_0000 + 32'(i));
        end
        next_cycle();
        next_cycle();
        for (int c = 2; c <= 6; c++) begin
            sample();
            check32("bp_valid", {31'b0, out_valid}, 32'h1);
            check32("bp_pc_held", out_pc, 32'h0);
            check32("bp_instr_held", out_instruction, 32'h1000_0000);
            check32("bp_addr_frozen", read_address, 32'h8);
            next_cycle();
        end
        out_ready = 1'b1;
        sample();
        check32("bp_release_addr", read_address, 32'h8);
        next_cycle();
        sample();
        check32("bp_resume_addr", read_address, 32'hC);
        repeat (5) next_cycle();
        drain_check("bp");

        // Redirect mid-stream at cycle 5 to 32'h43.
        out_ready = 1'b1;
        apply_reset();
        push_exp(32'h00, 32'h1000_0000);
        push_exp(32'h04, 32'h1000_0001);
        push_exp(32'h08, 32'h1000_0002);
        push_exp(32'h0C, 32'h1000_0003);
        push_exp(32'h40, 32'h1000_0010);
        push_exp(32'h44, 32'h1000_0011);
        push_exp(32'h48, 32'h1000_0012);
        repeat (5) next_cycle();
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0043;
        sample();
        next_cycle();
        redirect_valid = 1'b0;
        sample();
        check32("redir_c6_addr", read_address, 32'h40);
        check32("redir_c6_valid", {31'b0, out_valid}, 32'h0);
        next_cycle();
        sample();
        check32("redir_c7_valid", {31'b0, out_valid}, 32'h0);
        next_cycle();
        sample();
        check32("redir_c8_valid", {31'b0, out_valid}, 32'h1);
        check32("redir_c8_pc", out_pc, 32'h40);
        repeat (3) next_cycle();
        drain_check("redir");

        // Redirect with a simultaneous pop from a full buffer.
        out_ready = 1'b0;
        apply_reset();
        push_exp(32'h000, 32'h1000_0000);
        push_exp(32'h100, 32'h1000_0040);
        push_exp(32'h104, 32'h1000_0041);
        repeat (4) next_cycle();
        out_ready       = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0100;
        sample();
        check32("rpop_head_pc", out_pc, 32'h0);
        next_cycle();
        redirect_valid = 1'b0;
        sample();
        check32("rpop_c5_valid", {31'b0, out_valid}, 32'h0);
        check32("rpop_c5_addr", read_address, 32'h100);
        next_cycle();
        sample();
        check32("rpop_c6_valid", {31'b0, out_valid}, 32'h0);
        next_cycle();
        sample();
        check32("rpop_c7_pc", out_pc, 32'h100);
        repeat (2) next_cycle();
        drain_check("rpop");

        // PC wrap through the top of the address space.
        out_ready = 1'b1;
        apply_reset();
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFF8;
        push_exp(32'hFFFF_FFF8, 32'h4FFF_FFFE);
        push_exp(32'hFFFF_FFFC, 32'h4FFF_FFFF);
        push_exp(32'h0000_0000, 32'h1000_0000);
        push_exp(32'h0000_0004, 32'h1000_0001);
        sample();
        next_cycle();
        redirect_valid = 1'b0;
        sample();
        check32("wrap_c1_addr", read_address, 32'hFFFF_FFF8);
        next_cycle();
        sample();
        check32("wrap_c2_addr", read_address, 32'hFFFF_FFFC);
        next_cycle();
        sample();
        check32("wrap_c3_addr", read_address, 32'h0);
        check32("wrap_c3_pc", out_pc, 32'hFFFF_FFF8);
        next_cycle();
        sample();
        check32("wrap_c4_pc", out_pc, 32'hFFFF_FFFC);
        check32("wrap_c4_plus4", out_pc_plus4, 32'h0);
        next_cycle();
        sample();
        check32("wrap_c5_pc", out_pc, 32'h0);
        repeat (2) next_cycle();
        drain_check("wrap");

        // Asynchronous reset between edges while out_valid is high.
        out_ready = 1'b1;
        apply_reset();
        push_exp(32'h0, 32'h1000_0000);
        push_exp(32'h4, 32'h1000_0001);
        push_exp(32'h8, 32'h1000_0002);
        repeat (5) next_cycle();
        #1;
        check32("areset_pre_valid", {31'b0, out_valid}, 32'h1);
        reset_n = 1'b0;
        #1;
        check32("areset_valid", {31'b0, out_valid}, 32'h0);
        check32("areset_addr", read_address, 32'h0);
        check32("areset_pc", out_pc, 32'h0);
        drain_check("areset");
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        seq_body("restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
